// File: rtl/drac_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
// Optional AMO support is enabled by defining DMEM_RESPONDER_AMO_EN.
package drac_pkg;

  localparam logic [4:0] M_XRD    = 5'b00000;
  localparam logic [4:0] M_XWR    = 5'b00001;
  localparam logic [4:0] M_XLR    = 5'b00110;
  localparam logic [4:0] M_XSC    = 5'b00111;
  localparam logic [4:0] AMO_SWAP = 5'b00100;
  localparam logic [4:0] AMO_ADD  = 5'b01000;
  localparam logic [4:0] AMO_XOR  = 5'b01001;
  localparam logic [4:0] AMO_OR   = 5'b01010;
  localparam logic [4:0] AMO_AND  = 5'b01011;

  typedef enum logic [2:0] {
    BYTE   = 3'd0,
    HALF   = 3'd1,
    WORD   = 3'd2,
    DOUBLE = 3'd3,
    BYTE_U = 3'd4,
    HALF_U = 3'd5,
    WORD_U = 3'd6
  } op_type_t;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} dmem_resp_state_t;

  function automatic logic is_amo_cmd(logic [4:0] cmd);
    return (cmd == AMO_SWAP) || (cmd == AMO_ADD) || (cmd == AMO_XOR) ||
           (cmd == AMO_OR) || (cmd == AMO_AND);
  endfunction

  function automatic logic is_store_cmd(logic [4:0] cmd);
    return (cmd == M_XWR) || (cmd == M_XSC) || is_amo_cmd(cmd);
  endfunction

  function automatic logic is_word_op(logic [2:0] op);
    return (op == 3'(WORD)) || (op == 3'(WORD_U));
  endfunction

  function automatic logic misaligned(logic [2:0] op, logic [2:0] lane);
    case (op_type_t'(op))
      BYTE, BYTE_U: return 1'b0;
      HALF, HALF_U: return lane[0];
      WORD, WORD_U: return |lane[1:0];
      default:      return |lane;
    endcase
  endfunction

  function automatic logic [7:0] byte_en(logic [2:0] op, logic [2:0] lane);
    case (op_type_t'(op))
      BYTE, BYTE_U: return 8'h01 << lane;
      HALF, HALF_U: return 8'h03 << lane;
      WORD, WORD_U: return 8'h0F << lane;
      default:      return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] store_replicate(logic [2:0] op, logic [63:0] data);
    case (op_type_t'(op))
      BYTE, BYTE_U: return {8{data[7:0]}};
      HALF, HALF_U: return {4{data[15:0]}};
      WORD, WORD_U: return {2{data[31:0]}};
      default:      return data;
    endcase
  endfunction

  function automatic logic [63:0] load_extend(logic [2:0] op, logic [63:0] word,
                                              logic [2:0] lane);
    logic [63:0] sh;
    sh = word >> {lane, 3'b000};
    case (op_type_t'(op))
      BYTE:    return {{56{sh[7]}}, sh[7:0]};
      HALF:    return {{48{sh[15]}}, sh[15:0]};
      WORD:    return {{32{sh[31]}}, sh[31:0]};
      BYTE_U:  return {56'b0, sh[7:0]};
      HALF_U:  return {48'b0, sh[15:0]};
      WORD_U:  return {32'b0, sh[31:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/dmem_amo_alu.sv
// Combinational AMO datapath: old value and operand in, value to store out.
// Only instantiated when DMEM_RESPONDER_AMO_EN is defined.
module dmem_amo_alu
  import drac_pkg::*;
(
  input  logic [4:0]  amo_op_i,
  input  logic        is_word_i,
  input  logic [63:0] old_i,
  input  logic [63:0] operand_i,
  output logic [63:0] new_o
);

  logic [63:0] res;

  always_comb begin
    res = operand_i;
    case (amo_op_i)
      AMO_SWAP: res = operand_i;
      AMO_ADD:  res = old_i + operand_i;
      AMO_XOR:  res = old_i ^ operand_i;
      AMO_OR:   res = old_i | operand_i;
      AMO_AND:  res = old_i & operand_i;
      default:  res = operand_i;
    endcase
    new_o = is_word_i ? {{32{res[31]}}, res[31:0]} : res;
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding fixed-latency scratchpad responder for the core's dmem port.
// Define DMEM_RESPONDER_AMO_EN to support AMO_* commands; otherwise they are nacked.
module dmem_responder
  import drac_pkg::*;
#(
  parameter int unsigned ADDR_W    = 40,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              dmem_req_valid_i,
  input  logic [4:0]        dmem_req_cmd_i,
  input  logic [ADDR_W-1:0] dmem_req_addr_i,
  input  logic [2:0]        dmem_op_type_i,
  input  logic [DATA_W-1:0] dmem_req_data_i,
  input  logic [TAG_W-1:0]  dmem_req_tag_i,
  input  logic              dmem_req_invalidate_lr_i,
  input  logic              dmem_req_kill_i,
  input  logic              dmem_lock_i,
  output logic              dmem_req_ready_o,
  output logic              dmem_resp_valid_o,
  output logic [DATA_W-1:0] dmem_resp_data_o,
  output logic              dmem_resp_nack_o,
  output logic              dmem_resp_replay_o,
  output logic              dmem_xcpt_ma_st_o,
  output logic              dmem_xcpt_ma_ld_o,
  output logic              dmem_xcpt_pf_st_o,
  output logic              dmem_xcpt_pf_ld_o
);

  localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0]  LAT    = 4'(LATENCY);
  localparam logic [63:0] WIN_END = 64'(MEM_WORDS) << 3;

  dmem_resp_state_t   state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [4:0]         cmd_q, cmd_d;
  logic [2:0]         op_q, op_d;
  logic [2:0]         lane_q, lane_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [63:0]        wdata_q, wdata_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               lock_q, lock_d;
  logic               fault_q, fault_d;
  logic               kill_q, kill_d;
  logic               ma_ld_q, ma_ld_d, ma_st_q, ma_st_d;
  logic               pf_ld_q, pf_ld_d, pf_st_q, pf_st_d;
  logic               nack_q, nack_d;
  logic               resv_valid_q, resv_valid_d;
  logic [IDX_W-1:0]   resv_idx_q, resv_idx_d;

  logic [63:0]        mem [MEM_WORDS];

  logic               accept, req_store, req_ma, req_pf, req_nack, req_supported;
  logic               final_cyc, killed, commit, sc_ok, responds, do_write;
  logic [63:0]        old_val, amo_new, store_val, wr_data;
  logic [7:0]         wr_be;
  logic               unused_ok;

  assign accept        = dmem_req_valid_i && (state_q == IDLE);
  assign req_store     = is_store_cmd(dmem_req_cmd_i);
  assign req_ma        = misaligned(dmem_op_type_i, dmem_req_addr_i[2:0]);
  assign req_pf        = 64'(dmem_req_addr_i) >= WIN_END;
`ifdef DMEM_RESPONDER_AMO_EN
  assign req_supported = ((dmem_req_cmd_i == M_XRD) || (dmem_req_cmd_i == M_XWR) ||
                          (dmem_req_cmd_i == M_XLR) || (dmem_req_cmd_i == M_XSC) ||
                          is_amo_cmd(dmem_req_cmd_i)) && (dmem_op_type_i != 3'd7);
`else
  assign req_supported = ((dmem_req_cmd_i == M_XRD) || (dmem_req_cmd_i == M_XWR) ||
                          (dmem_req_cmd_i == M_XLR) || (dmem_req_cmd_i == M_XSC)) &&
                         (dmem_op_type_i != 3'd7);
`endif
  assign req_nack      = !req_supported;

  // Kill is only honoured in the first BUSY cycle; later it is carried in kill_q.
  assign killed    = kill_q || ((state_q == BUSY) && (cnt_q == 4'd1) && dmem_req_kill_i);
  assign final_cyc = (state_q == BUSY) && !fault_q && (cnt_q == LAT);
  assign commit    = final_cyc && !killed;
  assign sc_ok     = resv_valid_q && (resv_idx_q == idx_q);
  assign responds  = (cmd_q != M_XWR);
  assign old_val   = load_extend(op_q, mem[idx_q], lane_q);

`ifdef DMEM_RESPONDER_AMO_EN
  dmem_amo_alu u_amo_alu (
    .amo_op_i  (cmd_q),
    .is_word_i (is_word_op(op_q)),
    .old_i     (old_val),
    .operand_i (wdata_q),
    .new_o     (amo_new)
  );
`else
  assign amo_new = '0;
`endif

  assign store_val = is_amo_cmd(cmd_q) ? amo_new : wdata_q;
  assign wr_data   = store_replicate(op_q, store_val);
  assign wr_be     = byte_en(op_q, lane_q);
  assign do_write  = commit && rstn_i &&
                     ((cmd_q == M_XWR) || ((cmd_q == M_XSC) && sc_ok) || is_amo_cmd(cmd_q));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    op_d         = op_q;
    lane_d       = lane_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    tag_d        = tag_q;
    lock_d       = dmem_lock_i;
    fault_d      = fault_q;
    kill_d       = kill_q;
    ma_ld_d      = 1'b0;
    ma_st_d      = 1'b0;
    pf_ld_d      = 1'b0;
    pf_st_d      = 1'b0;
    nack_d       = 1'b0;
    resv_valid_d = resv_valid_q;
    resv_idx_d   = resv_idx_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = 4'd1;
          cmd_d   = dmem_req_cmd_i;
          op_d    = dmem_op_type_i;
          lane_d  = dmem_req_addr_i[2:0];
          idx_d   = dmem_req_addr_i[3 +: IDX_W];
          wdata_d = 64'(dmem_req_data_i);
          tag_d   = dmem_req_tag_i;
          kill_d  = 1'b0;
          fault_d = req_ma || req_pf || req_nack;
          ma_ld_d = req_ma && !req_store;
          ma_st_d = req_ma && req_store;
          pf_ld_d = !req_ma && req_pf && !req_store;
          pf_st_d = !req_ma && req_pf && req_store;
          nack_d  = !req_ma && !req_pf && req_nack;
        end
      end
      default: begin
        kill_d = killed;
        if (fault_q || (cnt_q == LAT)) begin
          state_d = IDLE;
          fault_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase

    // An LR commit outranks a same-cycle invalidate.
    if (commit && (cmd_q == M_XLR)) begin
      resv_valid_d = 1'b1;
      resv_idx_d   = idx_q;
    end else begin
      if (dmem_req_invalidate_lr_i) resv_valid_d = 1'b0;
      if (commit && ((cmd_q == M_XSC) ||
                     (((cmd_q == M_XWR) || is_amo_cmd(cmd_q)) && (resv_idx_q == idx_q))))
        resv_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cmd_q        <= '0;
      op_q         <= '0;
      lane_q       <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      tag_q        <= '0;
      lock_q       <= 1'b0;
      fault_q      <= 1'b0;
      kill_q       <= 1'b0;
      ma_ld_q      <= 1'b0;
      ma_st_q      <= 1'b0;
      pf_ld_q      <= 1'b0;
      pf_st_q      <= 1'b0;
      nack_q       <= 1'b0;
      resv_valid_q <= 1'b0;
      resv_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      op_q         <= op_d;
      lane_q       <= lane_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      tag_q        <= tag_d;
      lock_q       <= lock_d;
      fault_q      <= fault_d;
      kill_q       <= kill_d;
      ma_ld_q      <= ma_ld_d;
      ma_st_q      <= ma_st_d;
      pf_ld_q      <= pf_ld_d;
      pf_st_q      <= pf_st_d;
      nack_q       <= nack_d;
      resv_valid_q <= resv_valid_d;
      resv_idx_q   <= resv_idx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (wr_be[b]) mem[idx_q][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign dmem_req_ready_o   = (state_q == IDLE);
  assign dmem_resp_valid_o  = commit && responds;
  assign dmem_resp_data_o   = !(commit && responds) ? '0 :
                              (cmd_q == M_XSC) ? DATA_W'({63'b0, !sc_ok}) : DATA_W'(old_val);
  assign dmem_resp_nack_o   = nack_q;
  assign dmem_resp_replay_o = 1'b0;
  assign dmem_xcpt_ma_ld_o  = ma_ld_q;
  assign dmem_xcpt_ma_st_o  = ma_st_q;
  assign dmem_xcpt_pf_ld_o  = pf_ld_q;
  assign dmem_xcpt_pf_st_o  = pf_st_q;

  assign unused_ok = ^{tag_q, lock_q};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder against a byte-array reference model.
// Honours DMEM_RESPONDER_AMO_EN the same way the design does.
module tb_dmem_responder;
  import drac_pkg::*;

  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned WIN       = MEM_WORDS * 8;
`ifdef DMEM_RESPONDER_AMO_EN
  localparam bit AMO_EN = 1'b1;
`else
  localparam bit AMO_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        dmem_req_valid_i;
  logic [4:0]  dmem_req_cmd_i;
  logic [39:0] dmem_req_addr_i;
  logic [2:0]  dmem_op_type_i;
  logic [63:0] dmem_req_data_i;
  logic [7:0]  dmem_req_tag_i;
  logic        dmem_req_invalidate_lr_i;
  logic        dmem_req_kill_i;
  logic        dmem_lock_i;
  logic        dmem_req_ready_o;
  logic        dmem_resp_valid_o;
  logic [63:0] dmem_resp_data_o;
  logic        dmem_resp_nack_o;
  logic        dmem_resp_replay_o;
  logic        dmem_xcpt_ma_st_o;
  logic        dmem_xcpt_ma_ld_o;
  logic        dmem_xcpt_pf_st_o;
  logic        dmem_xcpt_pf_ld_o;

  dmem_responder #(
    .ADDR_W(40), .DATA_W(64), .TAG_W(8), .MEM_WORDS(MEM_WORDS), .LATENCY(2)
  ) dut (
    .clk_i                    (clk_i),
    .rstn_i                   (rstn_i),
    .dmem_req_valid_i         (dmem_req_valid_i),
    .dmem_req_cmd_i           (dmem_req_cmd_i),
    .dmem_req_addr_i          (dmem_req_addr_i),
    .dmem_op_type_i           (dmem_op_type_i),
    .dmem_req_data_i          (dmem_req_data_i),
    .dmem_req_tag_i           (dmem_req_tag_i),
    .dmem_req_invalidate_lr_i (dmem_req_invalidate_lr_i),
    .dmem_req_kill_i          (dmem_req_kill_i),
    .dmem_lock_i              (dmem_lock_i),
    .dmem_req_ready_o         (dmem_req_ready_o),
    .dmem_resp_valid_o        (dmem_resp_valid_o),
    .dmem_resp_data_o         (dmem_resp_data_o),
    .dmem_resp_nack_o         (dmem_resp_nack_o),
    .dmem_resp_replay_o       (dmem_resp_replay_o),
    .dmem_xcpt_ma_st_o        (dmem_xcpt_ma_st_o),
    .dmem_xcpt_ma_ld_o        (dmem_xcpt_ma_ld_o),
    .dmem_xcpt_pf_st_o        (dmem_xcpt_pf_st_o),
    .dmem_xcpt_pf_ld_o        (dmem_xcpt_pf_ld_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mbytes [0:8191];
  bit          resv_v = 1'b0;
  int unsigned resv_w = 0;
  logic [63:0] obs_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned m_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      default:    return 8;
    endcase
  endfunction

  function automatic logic [63:0] m_load(input int unsigned a, input logic [2:0] op);
    int unsigned n;
    logic [63:0] v;
    n = m_size(op);
    v = '0;
    for (int unsigned i = 0; i < n; i++) v = v | (64'(mbytes[a+i]) << (8*i));
    if (op <= 3'd2 && v[8*n-1]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction

  task automatic m_store(input int unsigned a, input logic [2:0] op, input logic [63:0] d);
    for (int unsigned i = 0; i < m_size(op); i++) mbytes[a+i] = d[8*i +: 8];
  endtask

  function automatic logic [63:0] amo_calc(input logic [4:0] cmd, input logic [63:0] old_v,
                                           input logic [63:0] opnd);
    case (cmd)
      AMO_ADD: return old_v + opnd;
      AMO_XOR: return old_v ^ opnd;
      AMO_OR:  return old_v | opnd;
      AMO_AND: return old_v & opnd;
      default: return opnd;
    endcase
  endfunction

  function automatic logic [4:0] pulses();
    return {dmem_xcpt_ma_ld_o, dmem_xcpt_ma_st_o, dmem_xcpt_pf_ld_o, dmem_xcpt_pf_st_o,
            dmem_resp_nack_o};
  endfunction

  // One full transaction: model prediction, drive, then cycle-by-cycle comparison.
  task automatic issue(input logic [4:0] cmd, input logic [2:0] op, input logic [39:0] addr,
                       input logic [63:0] data, input bit kill, input string tag);
    bit is_amo, is_st, sup, ma, pf, flt, e_rv;
    logic [4:0] e_pulse;
    logic [63:0] e_data, old_v;
    int unsigned a, w;
    is_amo = (cmd == AMO_SWAP) || (cmd == AMO_ADD) || (cmd == AMO_XOR) ||
             (cmd == AMO_OR) || (cmd == AMO_AND);
    is_st  = (cmd == M_XWR) || (cmd == M_XSC) || is_amo;
    sup    = ((cmd == M_XRD) || (cmd == M_XWR) || (cmd == M_XLR) || (cmd == M_XSC) ||
              (is_amo && AMO_EN)) && (op != 3'd7);
    ma     = (addr % m_size(op)) != 0;
    pf     = addr >= 40'(WIN);
    flt    = ma || pf || !sup;
    e_pulse = {ma && !is_st, ma && is_st, !ma && pf && !is_st, !ma && pf && is_st,
               !ma && !pf && !sup};
    e_rv = 1'b0;
    e_data = '0;
    a = addr[31:0];
    w = a / 8;
    if (!flt && !kill) begin
      if (cmd == M_XRD) begin
        e_rv = 1'b1; e_data = m_load(a, op);
      end else if (cmd == M_XWR) begin
        m_store(a, op, data);
        if (resv_v && resv_w == w) resv_v = 1'b0;
      end else if (cmd == M_XLR) begin
        e_rv = 1'b1; e_data = m_load(a, op); resv_v = 1'b1; resv_w = w;
      end else if (cmd == M_XSC) begin
        e_rv = 1'b1;
        if (resv_v && resv_w == w) begin e_data = 64'd0; m_store(a, op, data); end
        else e_data = 64'd1;
        resv_v = 1'b0;
      end else begin
        e_rv = 1'b1; old_v = m_load(a, op); e_data = old_v;
        m_store(a, op, amo_calc(cmd, old_v, data));
        if (resv_v && resv_w == w) resv_v = 1'b0;
      end
    end

    @(negedge clk_i);
    for (int i = 0; i < 16 && dmem_req_ready_o !== 1'b1; i++) @(negedge clk_i);
    chk({tag, ".ready_T"}, 64'(dmem_req_ready_o), 64'd1);
    dmem_req_valid_i = 1'b1;
    dmem_req_cmd_i   = cmd;
    dmem_op_type_i   = op;
    dmem_req_addr_i  = addr;
    dmem_req_data_i  = data;
    dmem_req_tag_i   = 8'($urandom);
    dmem_lock_i      = 1'($urandom);
    @(posedge clk_i);
    @(negedge clk_i);
    dmem_req_valid_i = 1'b0;
    dmem_req_kill_i  = kill;
    chk({tag, ".ready_T1"}, 64'(dmem_req_ready_o), 64'd0);
    chk({tag, ".pulse_T1"}, 64'(pulses()), 64'(e_pulse));
    chk({tag, ".rv_T1"}, 64'(dmem_resp_valid_o), 64'd0);
    @(negedge clk_i);
    dmem_req_kill_i = 1'b0;
    chk({tag, ".pulse_T2"}, 64'(pulses()), 64'd0);
    chk({tag, ".rv_T2"}, 64'(dmem_resp_valid_o), 64'(e_rv));
    obs_data = dmem_resp_data_o;
    if (e_rv) chk({tag, ".data_T2"}, dmem_resp_data_o, e_data);
    chk({tag, ".ready_T2"}, 64'(dmem_req_ready_o), flt ? 64'd1 : 64'd0);
    if (!flt) begin
      @(negedge clk_i);
      chk({tag, ".ready_T3"}, 64'(dmem_req_ready_o), 64'd1);
      chk({tag, ".rv_T3"}, 64'(dmem_resp_valid_o), 64'd0);
    end
  endtask

  task automatic pulse_inv();
    @(negedge clk_i);
    dmem_req_invalidate_lr_i = 1'b1;
    @(negedge clk_i);
    dmem_req_invalidate_lr_i = 1'b0;
    resv_v = 1'b0;
  endtask

  initial begin
    logic [4:0]  amo_list [5];
    logic [4:0]  cmd;
    logic [2:0]  op;
    logic [39:0] addr;
    int unsigned r, lane, n;
    bit          kill;
    amo_list = '{AMO_SWAP, AMO_ADD, AMO_XOR, AMO_OR, AMO_AND};

    rstn_i = 1'b0;
    dmem_req_valid_i = 1'b0; dmem_req_cmd_i = '0; dmem_req_addr_i = '0; dmem_op_type_i = '0;
    dmem_req_data_i = '0; dmem_req_tag_i = '0; dmem_req_invalidate_lr_i = 1'b0;
    dmem_req_kill_i = 1'b0; dmem_lock_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset.ready", 64'(dmem_req_ready_o), 64'd1);
    chk("reset.outs", 64'({dmem_resp_valid_o, dmem_resp_replay_o, pulses()}), 64'd0);
    chk("reset.data", dmem_resp_data_o, 64'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("post_reset.ready", 64'(dmem_req_ready_o), 64'd1);

    issue(M_XWR, 3'(DOUBLE), 40'h10, 64'h1122334455667788, 1'b0, "d.wr10");
    issue(M_XRD, 3'(DOUBLE), 40'h10, 64'd0, 1'b0, "d.rd10");
    chk("d.rd10.const", obs_data, 64'h1122334455667788);
    issue(M_XRD, 3'(BYTE), 40'h17, 64'd0, 1'b0, "d.rdb17");
    chk("d.rdb17.const", obs_data, 64'h11);
    issue(M_XRD, 3'(BYTE), 40'h10, 64'd0, 1'b0, "d.rdb10");
    chk("d.rdb10.const", obs_data, 64'hFFFFFFFFFFFFFF88);
    issue(M_XRD, 3'(BYTE_U), 40'h10, 64'd0, 1'b0, "d.rdbu10");
    chk("d.rdbu10.const", obs_data, 64'h88);
    issue(M_XRD, 3'(WORD), 40'h14, 64'd0, 1'b0, "d.rdw14");
    issue(M_XRD, 3'(HALF_U), 40'h16, 64'd0, 1'b0, "d.rdhu16");
    issue(M_XRD, 3'(WORD), 40'h12, 64'd0, 1'b0, "d.ma_ld");
    issue(M_XWR, 3'(DOUBLE), 40'h2000, 64'd1, 1'b0, "d.pf_st");
    issue(M_XRD, 3'(DOUBLE), 40'h1FF8, 64'd0, 1'b0, "d.last_word_init");

    issue(M_XWR, 3'(DOUBLE), 40'h20, 64'hAAAA, 1'b0, "d.init20");
    issue(M_XLR, 3'(DOUBLE), 40'h20, 64'd0, 1'b0, "d.lr20");
    issue(M_XSC, 3'(DOUBLE), 40'h20, 64'd5, 1'b0, "d.sc20_ok");
    chk("d.sc20_ok.const", obs_data, 64'd0);
    issue(M_XRD, 3'(DOUBLE), 40'h20, 64'd0, 1'b0, "d.rd20_5");
    chk("d.rd20_5.const", obs_data, 64'd5);
    issue(M_XLR, 3'(DOUBLE), 40'h20, 64'd0, 1'b0, "d.lr20b");
    pulse_inv();
    issue(M_XSC, 3'(DOUBLE), 40'h20, 64'd6, 1'b0, "d.sc20_fail");
    chk("d.sc20_fail.const", obs_data, 64'd1);
    issue(M_XRD, 3'(DOUBLE), 40'h20, 64'd0, 1'b0, "d.rd20_still5");

    issue(M_XWR, 3'(DOUBLE), 40'h30, 64'd7, 1'b0, "d.init30");
    issue(M_XWR, 3'(DOUBLE), 40'h30, 64'd9, 1'b1, "d.wr30_kill");
    issue(M_XRD, 3'(DOUBLE), 40'h30, 64'd0, 1'b0, "d.rd30");
    chk("d.rd30.const", obs_data, 64'd7);

    @(negedge clk_i);
    dmem_req_valid_i = 1'b1; dmem_req_cmd_i = M_XRD; dmem_op_type_i = 3'(DOUBLE);
    dmem_req_addr_i = 40'h10;
    @(posedge clk_i);
    @(negedge clk_i);
    dmem_req_valid_i = 1'b0;
    rstn_i = 1'b0;
    @(negedge clk_i);
    chk("rst_busy.rv", 64'(dmem_resp_valid_o), 64'd0);
    chk("rst_busy.ready", 64'(dmem_req_ready_o), 64'd1);
    rstn_i = 1'b1;
    resv_v = 1'b0;
    @(negedge clk_i);
    chk("rst_busy.rv_after", 64'(dmem_resp_valid_o), 64'd0);
    chk("rst_busy.ready_after", 64'(dmem_req_ready_o), 64'd1);

    issue(M_XWR, 3'(DOUBLE), 40'h40, 64'd3, 1'b0, "d.init40");
    issue(AMO_ADD, 3'(DOUBLE), 40'h40, 64'd4, 1'b0, "d.amoadd40");
    if (AMO_EN) chk("d.amoadd40.old", obs_data, 64'd3);
    issue(M_XRD, 3'(DOUBLE), 40'h40, 64'd0, 1'b0, "d.rd40");
    chk("d.rd40.const", obs_data, AMO_EN ? 64'd7 : 64'd3);

    for (int unsigned wd = 0; wd < 8; wd++)
      issue(M_XWR, 3'(DOUBLE), 40'(wd * 8), {$urandom, $urandom}, 1'b0, "r.init");
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 15);
      if (r < 5)       cmd = M_XRD;
      else if (r < 9)  cmd = M_XWR;
      else if (r < 11) cmd = M_XLR;
      else if (r < 13) cmd = M_XSC;
      else             cmd = amo_list[$urandom_range(0, 4)];
      op = 3'($urandom_range(0, 6));
      n = m_size(op);
      lane = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0) lane = lane - (lane % n);
      addr = 40'($urandom_range(0, 7) * 8 + lane);
      if ($urandom_range(0, 15) == 0) addr = 40'(WIN + $urandom_range(0, 255) * 8);
      kill = ((cmd == M_XRD) || (cmd == M_XWR) || (cmd == M_XLR)) && ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) pulse_inv();
      issue(cmd, op, addr, {$urandom, $urandom}, kill, $sformatf("r%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
